// File: rtl/fp_narrow_pkg.sv
// Purpose: shared rounding-mode encodings and encoding helpers for the mantissa narrowing unit.
// Latency: none (package only).
// Backpressure: n/a.
package fp_narrow_pkg;

    localparam logic [1:0] RND_TRUNC  = 2'b00;
    localparam logic [1:0] RND_HALFUP = 2'b01;
    localparam logic [1:0] RND_RNE    = 2'b10;

    // Largest finite {exponent, mantissa} pattern: exponent all-ones minus one, mantissa all-ones.
    function automatic logic [31:0] sat_max_enc(input int ew, input int dmw);
        logic [31:0] e_max;
        logic [31:0] m_max;
        e_max = (32'd1 << ew) - 32'd2;
        m_max = (32'd1 << dmw) - 32'd1;
        return (e_max << dmw) | m_max;
    endfunction

endpackage

// File: rtl/fp_narrow_lane.sv
// Purpose: one combinational lane: round decision, mantissa carry into exponent, overflow flag, encoding.
// Latency: 0 cycles (pure combinational). Optional FP_NARROW_SAT_EN: overflow saturates to max finite.
// Backpressure: none; the enclosing pipeline owns all flow control.
module fp_narrow_lane
    import fp_narrow_pkg::*;
#(
    parameter int EW     = 2,
    parameter int SRC_MW = 3,
    parameter int DST_MW = 1
) (
    input  logic [1:0]        rnd_mode_i,
    input  logic              sign_i,
    input  logic [EW-1:0]     exp_i,
    input  logic [SRC_MW-1:0] man_i,
    output logic              sign_o,
    output logic [EW-1:0]     exp_o,
    output logic [DST_MW-1:0] man_o,
    output logic              ovf_o
);

    // Number of mantissa bits being discarded (at least one: the guard bit).
    localparam int LOW = SRC_MW - DST_MW;
    localparam logic [EW-1:0] EXP_ONES = '1;
`ifdef FP_NARROW_SAT_EN
    localparam logic [EW+DST_MW-1:0] SAT_ENC = (EW+DST_MW)'(sat_max_enc(EW, DST_MW));
`endif

    logic [DST_MW-1:0] keep;
    logic              g;
    logic              s;
    logic              up;
    logic [DST_MW:0]   m;
    logic              carry;
    logic [EW-1:0]     exp_inc;

    // Round decision, carry propagation into the exponent and final lane encoding.
    always_comb begin
        keep = man_i[SRC_MW-1 -: DST_MW];
        g    = man_i[LOW-1];
        s    = 1'b0;
        for (int i = 0; i < LOW - 1; i++) begin
            s = s | man_i[i];
        end
        case (rnd_mode_i)
            RND_TRUNC:  up = 1'b0;
            RND_HALFUP: up = g;
            default:    up = g & (s | keep[0]);
        endcase
        m       = {1'b0, keep} + {{DST_MW{1'b0}}, up};
        carry   = m[DST_MW];
        exp_inc = exp_i + EW'(carry);

        sign_o = sign_i;
        ovf_o  = 1'b0;
        exp_o  = exp_inc;
        man_o  = m[DST_MW-1:0];
        if (exp_i == EXP_ONES) begin
            // Inf/NaN class passes through as Inf of the same sign; not an overflow.
            exp_o = EXP_ONES;
            man_o = '0;
        end else if (exp_inc == EXP_ONES) begin
            // Only reachable through a mantissa carry: the rounded value left the finite range.
            ovf_o = 1'b1;
`ifdef FP_NARROW_SAT_EN
            {exp_o, man_o} = SAT_ENC;
`else
            exp_o = EXP_ONES;
            man_o = '0;
`endif
        end
    end

endmodule

// File: rtl/fp_narrow_round_pipe.sv
// Purpose: LANES-wide mantissa narrowing with selectable rounding and a saturating overflow-lane counter.
// Latency: 2 register stages (S1 rounded fields, S2 packed result); FP_NARROW_SAT_EN selects saturation.
// Backpressure: valid/ready; each stage advances when its successor is empty or draining, in_ready = en1.
module fp_narrow_round_pipe
    import fp_narrow_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int EW     = 2,
    parameter int SRC_MW = 3,
    parameter int DST_MW = 1,
    parameter int CW     = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      rnd_mode,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*(1+EW+SRC_MW)-1:0]  in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*(1+EW+DST_MW)-1:0]  out_data,
    output logic [CW-1:0]                   ovf_cnt,
    input  logic                            cnt_clr
);

    localparam int IW = 1 + EW + SRC_MW;
    localparam int OW = 1 + EW + DST_MW;

    logic [LANES-1:0]              l_sign;
    logic [LANES-1:0][EW-1:0]      l_exp;
    logic [LANES-1:0][DST_MW-1:0]  l_man;
    logic [LANES-1:0]              l_ovf;

    logic                          v1_q, v2_q;
    logic [LANES-1:0]              s1_sign_q;
    logic [LANES-1:0][EW-1:0]      s1_exp_q;
    logic [LANES-1:0][DST_MW-1:0]  s1_man_q;
    logic [LANES*OW-1:0]           out_data_q, out_data_d;
    logic [CW-1:0]                 ovf_cnt_q, ovf_cnt_d;
    logic [CW:0]                   ovf_lanes, cnt_sum;
    logic                          en1, en2, accept;

    // rnd_mode feeds the lanes directly, so it is effectively captured into S1 with the beat.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp_narrow_lane #(
            .EW     (EW),
            .SRC_MW (SRC_MW),
            .DST_MW (DST_MW)
        ) u_lane (
            .rnd_mode_i (rnd_mode),
            .sign_i     (in_data[i*IW + IW - 1]),
            .exp_i      (in_data[i*IW + SRC_MW +: EW]),
            .man_i      (in_data[i*IW +: SRC_MW]),
            .sign_o     (l_sign[i]),
            .exp_o      (l_exp[i]),
            .man_o      (l_man[i]),
            .ovf_o      (l_ovf[i])
        );
    end

    assign en2       = !v2_q || out_ready;
    assign en1       = !v1_q || en2;
    assign in_ready  = en1;
    assign accept    = in_valid && en1;
    assign out_valid = v2_q;
    assign out_data  = out_data_q;
    assign ovf_cnt   = ovf_cnt_q;

    // Pack S1 fields into the output lane layout (lane 0 in the LSBs).
    always_comb begin
        out_data_d = '0;
        for (int i = 0; i < LANES; i++) begin
            out_data_d[i*OW +: OW] = {s1_sign_q[i], s1_exp_q[i], s1_man_q[i]};
        end
    end

    // Overflow-lane count for the incoming beat and saturating accumulation; clear wins.
    always_comb begin
        ovf_lanes = '0;
        for (int i = 0; i < LANES; i++) begin
            ovf_lanes = ovf_lanes + (CW+1)'(l_ovf[i]);
        end
        cnt_sum   = {1'b0, ovf_cnt_q} + ovf_lanes;
        ovf_cnt_d = ovf_cnt_q;
        if (cnt_clr) begin
            ovf_cnt_d = '0;
        end else if (accept) begin
            ovf_cnt_d = cnt_sum[CW] ? '1 : cnt_sum[CW-1:0];
        end
    end

    // Stage 1: rounded sign/exponent/mantissa per lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q      <= 1'b0;
            s1_sign_q <= '0;
            s1_exp_q  <= '0;
            s1_man_q  <= '0;
        end else if (en1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= l_sign;
                s1_exp_q  <= l_exp;
                s1_man_q  <= l_man;
            end
        end
    end

    // Stage 2: packed result, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q       <= 1'b0;
            out_data_q <= '0;
        end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                out_data_q <= out_data_d;
            end
        end
    end

    // Overflow counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

endmodule

// File: tb/tb_fp_narrow_round_pipe.sv
// Purpose: directed self-checking bench for fp_narrow_round_pipe (FP6 -> FP4, 4 lanes).
// Latency: expects results two register edges after a beat is presented.
// Backpressure: exercises out_ready stalls, hold stability and in_ready deassertion.
module tb_fp_narrow_round_pipe;

    logic        clk;
    logic        rst;
    logic [1:0]  rnd_mode;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [15:0] ovf_cnt;
    logic        cnt_clr;

    int vectors;
    int miscompares;

`ifdef FP_NARROW_SAT_EN
    localparam logic [15:0] EXP_OVF4 = 16'h5555;
    localparam logic [15:0] EXP_MIX  = 16'h556D;
`else
    localparam logic [15:0] EXP_OVF4 = 16'h6666;
    localparam logic [15:0] EXP_MIX  = 16'h556E;
`endif
    localparam logic [23:0] OVF4_IN = {4{6'b010110}};

    fp_narrow_round_pipe #(
        .LANES(4), .EW(2), .SRC_MW(3), .DST_MW(1), .CW(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rnd_mode  (rnd_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf_cnt   (ovf_cnt),
        .cnt_clr   (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, check two-edge latency, return the result.
    task automatic beat(input logic [23:0] d, input logic [1:0] m, output logic [15:0] r);
        in_data  = d;
        rnd_mode = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_stage1_not_out", 32'(out_valid), 32'd0);
        tick();
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        r = out_data;
    endtask

    // Backpressure stream: lane j has sign j[0], exponent (k+j)%3, mantissa (3k+j)%8.
    function automatic logic [23:0] bp_in(input int k);
        logic [23:0] d;
        d = '0;
        for (int j = 0; j < 4; j++) begin
            d[j*6 +: 6] = {1'(j), 2'((k + j) % 3), 3'(k * 3 + j)};
        end
        return d;
    endfunction

    // Truncation of a finite value keeps the mantissa MSB.
    function automatic logic [15:0] bp_exp(input int k);
        logic [15:0] o;
        o = '0;
        for (int j = 0; j < 4; j++) begin
            o[j*4 +: 4] = {1'(j), 2'((k + j) % 3), 1'((k * 3 + j) >> 2)};
        end
        return o;
    endfunction

    logic [15:0] r;
    logic [15:0] exp_q[$];
    logic [15:0] held;
    logic        held_vld;
    int          sent, got, cyc;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        rnd_mode    = 2'b00;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        cnt_clr     = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed rounding vectors.
        beat({6'b100011, 6'b000000, 6'b001100, 6'b001110}, 2'b01, r);
        chk("halfup_mixed", 32'(r), 32'h9034);
        chk("halfup_no_ovf", 32'(ovf_cnt), 32'd0);
        beat(OVF4_IN, 2'b01, r);
        chk("halfup_ovf4", 32'(r), 32'(EXP_OVF4));
        chk("halfup_ovf4_cnt", 32'(ovf_cnt), 32'd4);
        beat({6'b001110, 6'b100110, 6'b001011, 6'b001010}, 2'b10, r);
        chk("rne_ties", 32'(r), 32'h4A32);
        beat({6'b000100, 6'b110111, 6'b010110, 6'b001111}, 2'b00, r);
        chk("trunc", 32'(r), 32'h1D53);
        beat({6'b010100, 6'b010010, 6'b001110, 6'b001010}, 2'b11, r);
        chk("mode3_as_rne", 32'(r), 32'h5442);
        chk("no_ovf_cnt", 32'(ovf_cnt), 32'd4);
        beat({6'b010011, 6'b010101, 6'b011000, 6'b110111}, 2'b10, r);
        chk("rne_mixed_ovf", 32'(r), 32'(EXP_MIX));
        chk("rne_mixed_cnt", 32'(ovf_cnt), 32'd5);
        for (int md = 0; md < 4; md++) begin
            beat({4{6'b111101}}, 2'(md), r);
            chk("inf_nan", 32'(r), 32'hEEEE);
        end
        chk("inf_nan_cnt", 32'(ovf_cnt), 32'd5);

        // Counter clear, preload to max-1, saturation, clear beating an increment.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_clr_idle", 32'(ovf_cnt), 32'd0);
        in_data  = OVF4_IN;
        rnd_mode = 2'b01;
        in_valid = 1'b1;
        repeat (16383) tick();
        in_data = {6'b000000, 6'b000000, 6'b010110, 6'b010110};
        tick();
        in_valid = 1'b0;
        chk("cnt_preload", 32'(ovf_cnt), 32'd65534);
        in_data  = OVF4_IN;
        in_valid = 1'b1;
        tick();
        chk("cnt_saturate", 32'(ovf_cnt), 32'd65535);
        tick();
        chk("cnt_stay_sat", 32'(ovf_cnt), 32'd65535);
        cnt_clr = 1'b1;
        tick();
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
        chk("cnt_clr_with_ovf", 32'(ovf_cnt), 32'd0);
        tick();
        tick();
        chk("drained", 32'(out_valid), 32'd0);

        // Backpressure stream, out_ready pattern 1,0,0,1 per cycle.
        sent     = 0;
        got      = 0;
        cyc      = 0;
        held_vld = 1'b0;
        held     = '0;
        rnd_mode = 2'b00;
        while (got < 8 && cyc < 200) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (sent < 8);
            in_data   = bp_in(sent);
            @(negedge clk);
            if (cyc == 2) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            if (held_vld) chk("bp_hold", 32'(out_data), 32'(held));
            if (out_valid && out_ready) begin
                chk("bp_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("bp_data", 32'(out_data), 32'(exp_q.pop_front()));
                got++;
            end
            held_vld = out_valid && !out_ready;
            held     = out_data;
            if (in_valid && in_ready) begin
                exp_q.push_back(bp_exp(sent));
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_beats_out", 32'(got), 32'd8);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();
        chk("bp_no_duplicate", 32'(out_valid), 32'd0);
        chk("bp_cnt_unchanged", 32'(ovf_cnt), 32'd0);

        // Asynchronous reset with a full, stalled pipeline.
        out_ready = 1'b0;
        in_data   = OVF4_IN;
        rnd_mode  = 2'b01;
        in_valid  = 1'b1;
        tick();
        tick();
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        chk("pre_rst_cnt", 32'(ovf_cnt), 32'd8);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_cnt", 32'(ovf_cnt), 32'd0);
        chk("async_rst_data", 32'(out_data), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("post_rst_discarded", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
